// File: rtl/axil_reg_seq_master.sv
// axil_reg_seq_master
// AXI4-Lite master that writes a fixed table of test words to consecutive
// registers of the myip S00_AXI slave, reads each one back, and reports
// TXN_DONE plus a sticky ERROR flag. Used as an on-chip self-test.
//
// Build option: define AXIL_SEQ_STOP_ON_ERROR_EN to end the run at the first
// failing compare. Without it every vector runs and ERROR accumulates.
//
// state | meaning
// IDLE  | waiting for a start edge; TXN_DONE/ERROR hold the last result
// WR    | AW and W valid until each handshakes; leave once both are done
// WRESP | BREADY high, waiting for the write response
// RD    | ARVALID high until ARREADY
// RDATA | RREADY high, waiting for read data
// CMP   | check both responses and the read-back word, pick next step
// DONE  | single cycle with TXN_DONE raised, then back to IDLE
module axil_reg_seq_master #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH         = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH         = 32,
  parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h0000_0000,
  parameter int unsigned C_M_TRANSACTIONS_NUM       = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic                              INIT_TXN,
  output logic                              TXN_DONE,
  output logic                              ERROR,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
  localparam logic [AW-1:0] BASE     = AW'(C_M_TARGET_SLAVE_BASE_ADDR);
  localparam logic [1:0]    LAST_IDX = 2'(C_M_TRANSACTIONS_NUM - 1);

`ifdef AXIL_SEQ_STOP_ON_ERROR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WRESP,
    S_RD,
    S_RDATA,
    S_CMP,
    S_DONE
  } state_t;

  state_t          state;
  logic [1:0]      idx;
  logic            aw_done;
  logic            w_done;
  logic [1:0]      bresp_q;
  logic [1:0]      rresp_q;
  logic [DW-1:0]   rdata_q;
  logic            init_q;
  logic            start_pls;
  logic            cmp_fail;
  logic            finish;

  function automatic logic [DW-1:0] vec_of(input logic [1:0] i);
    logic [31:0] v;
    case (i)
      2'd0:    v = 32'h0101_FFFF;
      2'd1:    v = 32'hABCD_0001;
      2'd2:    v = 32'hDEAD_0011;
      default: v = 32'hBEEF_0011;
    endcase
    return DW'(v);
  endfunction

  // Register address wraps naturally at the address width.
  function automatic logic [AW-1:0] addr_of(input logic [1:0] i);
    return BASE + AW'({i, 2'b00});
  endfunction

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB  = '1;

  assign cmp_fail = (bresp_q != 2'b00) || (rresp_q != 2'b00) || (rdata_q != vec_of(idx));
  assign finish   = (idx == LAST_IDX) || (STOP_ON_ERR && cmp_fail);

  // Registered start edge: a held-high INIT_TXN yields a single pulse.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      init_q    <= 1'b0;
      start_pls <= 1'b0;
    end else begin
      init_q    <= INIT_TXN;
      start_pls <= INIT_TXN & ~init_q;
    end
  end

  // Sequencer with all AXI handshake outputs and status flags registered.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state         <= S_IDLE;
      idx           <= 2'd0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      bresp_q       <= 2'b00;
      rresp_q       <= 2'b00;
      rdata_q       <= '0;
      TXN_DONE      <= 1'b0;
      ERROR         <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_pls) begin
            TXN_DONE      <= 1'b0;
            ERROR         <= 1'b0;
            idx           <= 2'd0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            M_AXI_AWADDR  <= addr_of(2'd0);
            M_AXI_WDATA   <= vec_of(2'd0);
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            state         <= S_WR;
          end
        end
        S_WR: begin
          if (M_AXI_AWVALID && M_AXI_AWREADY) begin
            M_AXI_AWVALID <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (M_AXI_WVALID && M_AXI_WREADY) begin
            M_AXI_WVALID <= 1'b0;
            w_done       <= 1'b1;
          end
          // Move on from the registered flags so both channels settle first.
          if (aw_done && w_done) begin
            M_AXI_BREADY <= 1'b1;
            state        <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (M_AXI_BVALID) begin
            bresp_q       <= M_AXI_BRESP;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= addr_of(idx);
            M_AXI_ARVALID <= 1'b1;
            state         <= S_RD;
          end
        end
        S_RD: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (M_AXI_RVALID) begin
            rdata_q      <= M_AXI_RDATA;
            rresp_q      <= M_AXI_RRESP;
            M_AXI_RREADY <= 1'b0;
            state        <= S_CMP;
          end
        end
        S_CMP: begin
          ERROR <= ERROR | cmp_fail;
          if (finish) begin
            TXN_DONE <= 1'b1;
            state    <= S_DONE;
          end else begin
            idx           <= idx + 2'd1;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            M_AXI_AWADDR  <= addr_of(idx + 2'd1);
            M_AXI_WDATA   <= vec_of(idx + 2'd1);
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            state         <= S_WR;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/axil_reg_seq_master.md
# axil_reg_seq_master

Synthesizable AXI4-Lite master that replaces the simulation BFM in front of the `myip` S00_AXI register slave. On a start pulse it runs a fixed write-then-read-back sequence over consecutive slave registers. It checks every response for OKAY and every read-back against the written word, then reports done and pass/fail. It sits directly upstream of the slave's S00_AXI port in the block design and is used as an on-chip self-test.

## Interface
- `C_M_AXI_ADDR_WIDTH`, 32: address width.
- `C_M_AXI_DATA_WIDTH`, 32: data width; only 32 is supported.
- `C_M_TARGET_SLAVE_BASE_ADDR`, 32'h0000_0000: address of the first register.
- `C_M_TRANSACTIONS_NUM`, 4: number of registers exercised, 1..4.

Ports:
- `ACLK` in 1: clock; all logic on the rising edge.
- `ARESET` in 1: reset; synchronous and active-high.
- `INIT_TXN` in 1: start request; acted on at its rising edge.
- `TXN_DONE` out 1: sequence finished; held until the next start.
- `ERROR` out 1: sticky failure flag for the current run.
- `M_AXI_AWADDR` out ADDR: write address.
- `M_AXI_AWPROT` out 3: fixed 3'b000.
- `M_AXI_AWVALID` out 1; `M_AXI_AWREADY` in 1.
- `M_AXI_WDATA` out 32: write data.
- `M_AXI_WSTRB` out 4: fixed 4'hF.
- `M_AXI_WVALID` out 1; `M_AXI_WREADY` in 1.
- `M_AXI_BRESP` in 2; `M_AXI_BVALID` in 1; `M_AXI_BREADY` out 1.
- `M_AXI_ARADDR` out ADDR: read address.
- `M_AXI_ARPROT` out 3: fixed 3'b000.
- `M_AXI_ARVALID` out 1; `M_AXI_ARREADY` in 1.
- `M_AXI_RDATA` in 32; `M_AXI_RRESP` in 2; `M_AXI_RVALID` in 1; `M_AXI_RREADY` out 1.

## Operation
- Test vector table, index i: 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011.
- Vector i uses address BASE + 4*i. Addresses are computed modulo 2^ADDR.
- States:
  - IDLE: on INIT_TXN 0→1, clear `TXN_DONE`, `ERROR` and the index, then go to WR.
  - WR: drive AWVALID and WVALID together. Each drops in the cycle after its own handshake. Go to WRESP once both handshakes have completed, in either order or in the same cycle.
  - WRESP: drive BREADY=1. On BVALID, record the response, then go to RD.
  - RD: drive ARVALID until ARREADY, then go to RDATA.
  - RDATA: drive RREADY=1. On RVALID, capture RDATA and RRESP, then go to CMP.
  - CMP: set ERROR if either response was not 2'b00 or the read data differs from the vector. If index = N-1, go to DONE; otherwise increment the index and go to WR.
  - DONE: `TXN_DONE`=1, then go to IDLE in the next cycle. `TXN_DONE` stays high after that.
- Address and data outputs are stable while their VALID is high.
- VALID is never withdrawn before its handshake.
- `INIT_TXN` edges are ignored outside IDLE.
- The start edge detector registers `INIT_TXN`. A level held high starts only one run.

## Timing
- Reset values: all VALID and READY outputs 0; `TXN_DONE` 0; `ERROR` 0; index 0; state IDLE; ADDR and DATA outputs 0.
- Reset mid-transaction: all VALIDs drop at the reset edge and the run is abandoned.
- AWVALID and WVALID rise 2 cycles after the `INIT_TXN` rising edge (edge-detect register, then state register).
- With a zero-wait slave, one vector takes 6 cycles: WR, WRESP, RD, RDATA, CMP, plus one handshake cycle.
- BREADY and RREADY are high only in WRESP and RDATA. A BVALID or RVALID that arrives earlier is held by the slave.
- `ERROR` updates in the CMP cycle and is visible on the next edge.
- `TXN_DONE` rises one cycle after the last CMP.

## Configuration
- `AXIL_SEQ_STOP_ON_ERROR_EN`:
  - Defined: the first failing CMP goes straight to DONE with `ERROR`=1. Remaining vectors are skipped.
  - Undefined: every vector runs regardless of failures, and `ERROR` accumulates.

## Test plan
- Zero-wait 4-register slave, N=4, BASE=0x0: writes 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to 0x0, 0x4, 0x8, 0xC, with a read-back after each. Required: `TXN_DONE`=1, `ERROR`=0, total 24 cycles from the first AWVALID to `TXN_DONE`.
- AWREADY delayed 3 cycles and WREADY immediate, then the reverse: WVALID drops after 1 cycle, AWVALID is held until its handshake, and there is exactly one write per address.
- Slave returns BRESP=2'b10 on vector 1:
  - Macro defined: `TXN_DONE` and `ERROR` are set after vector 1, and there is no AW to 0x8.
  - Macro undefined: all 4 vectors run and `ERROR`=1.
- Slave corrupts the read of 0x8 to 0xDEAD0010: `ERROR`=1. Writes to 0x0 and 0x4 are still correct.
- Assert ARESET while AWVALID=1 during vector 2: all VALIDs are 0 on the next edge and `TXN_DONE`=0. A later `INIT_TXN` restarts at BASE.
- `INIT_TXN` is held high or pulsed again during a run: exactly one sequence executes.
